// File: rtl/inst_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_if
//   Handshake bundle between fetch (push side), decode (pop side) and the
//   instruction fetch queue.
//   master : fetch/decode side, drives flush, push_valid/push_inst/push_pc and
//            pop_ready; observes everything the queue reports.
//   slave  : the queue itself.
//   Signals:
//     flush         redirect, discard every queued entry
//     push_valid    fetch presents {push_pc, push_inst}
//     push_ready    queue can accept (occupancy below DEPTH)
//     push_inst     fetched instruction word
//     push_pc       PC of push_inst
//     pop_valid     head entry valid
//     pop_ready     decode consumes the head
//     pop_inst      head instruction (NOP when nothing valid)
//     pop_imm_field pop_inst[31:7] for the immediate generator
//     pop_pc        head PC (0 when nothing valid)
//     count         current occupancy
// -----------------------------------------------------------------------------
interface inst_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             flush;
  logic             push_valid;
  logic             push_ready;
  logic [31:0]      push_inst;
  logic [31:0]      push_pc;
  logic             pop_valid;
  logic             pop_ready;
  logic [31:0]      pop_inst;
  logic [24:0]      pop_imm_field;
  logic [31:0]      pop_pc;
  logic [PTR_W:0]   count;

  modport master (
    output flush, push_valid, push_inst, push_pc, pop_ready,
    input  push_ready, pop_valid, pop_inst, pop_imm_field, pop_pc, count
  );

  modport slave (
    input  flush, push_valid, push_inst, push_pc, pop_ready,
    output push_ready, pop_valid, pop_inst, pop_imm_field, pop_pc, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Small FIFO of {pc, instruction} pairs between fetch and decode, so a
//   decode stall does not throttle the fetch path cycle by cycle. The head
//   entry is presented combinationally; a redirect (flush) empties the queue.
//
//   Parameters:
//     DEPTH    number of entries (power of two, >= 2)
//     NOP_INST word shown on pop_inst when no valid head (addi x0,x0,0)
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     q    inst_fetch_queue_if.slave (push/pop handshakes, flush, count)
//
//   Build option:
//     IFQ_BYPASS_EN  when defined, an instruction pushed into an empty queue
//                    while decode is ready goes straight to the pop outputs in
//                    the same cycle and is never written. Undefined: push to
//                    pop latency is always one cycle.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic                  clk,
  input logic                  rst,
  inst_fetch_queue_if.slave    q
);
  localparam int             PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;

  logic head_valid;
  logic bypass;
  logic push_fire;
  logic pop_fire;

  assign head_valid = (count_q != '0);

`ifdef IFQ_BYPASS_EN
  // Empty queue, decode ready: hand the fetched word straight through.
  assign bypass = !head_valid && q.push_valid && q.pop_ready && !q.flush;
`else
  assign bypass = 1'b0;
`endif

  // push_ready comes only from the registered count, so fetch never sees a
  // combinational path from pop_ready or flush.
  assign q.push_ready = (count_q != FULL_COUNT);

  // A bypassed instruction is consumed on the spot and must not be stored.
  assign push_fire = q.push_valid && q.push_ready && !bypass;
  assign pop_fire  = head_valid && q.pop_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      // Redirect wins over any push or pop in the same cycle.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural overflow.
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever observed after
  // it has been written, and leaving it unreset lets it map to plain RAM/flops
  // without a reset network.
  always_ff @(posedge clk) begin
    // rst gates the write so a reset overlapping an edge leaves no stray entry.
    if (push_fire && !q.flush && !rst) begin
      mem[wr_ptr] <= '{pc: q.push_pc, inst: q.push_inst};
    end
  end

  // NOTE: every output gets its default first, so no path through this block
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    q.pop_valid = 1'b0;
    q.pop_inst  = NOP_INST;
    q.pop_pc    = '0;
    if (head_valid) begin
      q.pop_valid = 1'b1;
      q.pop_inst  = mem[rd_ptr].inst;
      q.pop_pc    = mem[rd_ptr].pc;
    end else if (bypass) begin
      q.pop_valid = 1'b1;
      q.pop_inst  = q.push_inst;
      q.pop_pc    = q.push_pc;
    end
  end

  assign q.pop_imm_field = q.pop_inst[31:7];
  assign q.count         = count_q;

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= FULL_COUNT);

  // When full the pointers coincide, so the low count bits only track the
  // pointer distance below full.
  a_count_ptrs : assert property (@(posedge clk) disable iff (rst)
    (count_q != FULL_COUNT) |-> (count_q[PTR_W-1:0] == PTR_W'(wr_ptr - rd_ptr)));
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed bench for inst_fetch_queue. A queue-based model tracks what the
//   head must be each cycle; a negedge process compares every output against
//   it, and the directed sequence pins the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) ifc ();

  inst_fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .q   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  ent_t mq[$];

  function automatic logic model_bypass();
`ifdef IFQ_BYPASS_EN
    return (mq.size() == 0) && ifc.push_valid && ifc.pop_ready && !ifc.flush;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (ifc.flush) begin
      mq.delete();
    end else begin
      logic pop_f, push_f;
      pop_f  = (mq.size() != 0) && ifc.pop_ready;
      push_f = ifc.push_valid && (mq.size() != DEPTH) && !model_bypass();
      if (pop_f)  void'(mq.pop_front());
      if (push_f) mq.push_back('{pc: ifc.push_pc, inst: ifc.push_inst});
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_inst, e_pc;
    e_valid = 1'b0;
    e_inst  = NOP;
    e_pc    = '0;
    if (mq.size() != 0) begin
      e_valid = 1'b1;
      e_inst  = mq[0].inst;
      e_pc    = mq[0].pc;
    end else if (model_bypass()) begin
      e_valid = 1'b1;
      e_inst  = ifc.push_inst;
      e_pc    = ifc.push_pc;
    end
    check("cmp_count",      32'(ifc.count),         32'(mq.size()));
    check("cmp_push_ready", 32'(ifc.push_ready),    32'(mq.size() != DEPTH));
    check("cmp_pop_valid",  32'(ifc.pop_valid),     32'(e_valid));
    check("cmp_pop_inst",   ifc.pop_inst,           e_inst);
    check("cmp_pop_pc",     ifc.pop_pc,             e_pc);
    check("cmp_imm",        32'(ifc.pop_imm_field), 32'(e_inst[31:7]));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.flush      = 1'b0;
    ifc.push_valid = 1'b0;
    ifc.pop_ready  = 1'b0;
  endtask

  logic [31:0] got[$];
  logic        acc;

  initial begin
    rst            = 1'b1;
    ifc.push_inst  = '0;
    ifc.push_pc    = '0;
    idle();
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    check("rst_count",      32'(ifc.count),      0);
    check("rst_pop_valid",  32'(ifc.pop_valid),  0);
    check("rst_pop_inst",   ifc.pop_inst,        32'h0000_0013);
    check("rst_pop_pc",     ifc.pop_pc,          0);
    check("rst_push_ready", 32'(ifc.push_ready), 1);

    // Single entry, decode stalled
    ifc.push_valid = 1'b1;
    ifc.push_inst  = 32'h0050_0093;
    ifc.push_pc    = 32'h0000_0100;
    cyc();
    ifc.push_valid = 1'b0;
    check("single_valid", 32'(ifc.pop_valid),     1);
    check("single_inst",  ifc.pop_inst,           32'h0050_0093);
    check("single_imm",   32'(ifc.pop_imm_field), 32'h000_A001);
    check("single_pc",    ifc.pop_pc,             32'h100);
    check("single_count", 32'(ifc.count),         1);
    ifc.pop_ready = 1'b1;
    cyc();
    ifc.pop_ready = 1'b0;
    check("single_drained", 32'(ifc.count), 0);

    // Fill and stall: four accepted, fifth held
    for (int i = 0; i < 4; i++) begin
      ifc.push_valid = 1'b1;
      ifc.push_pc    = 32'(i * 4);
      ifc.push_inst  = {12'(i + 1), 20'h00093};
      cyc();
    end
    check("full_push_ready", 32'(ifc.push_ready), 0);
    check("full_count",      32'(ifc.count),      4);
    ifc.push_pc   = 32'h10;
    ifc.push_inst = {12'd5, 20'h00093};
    cyc();
    check("full_held_count", 32'(ifc.count), 4);
    ifc.pop_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 12 && got.size() < 5; k++) begin
      if (ifc.pop_valid) got.push_back(ifc.pop_pc);
      acc = ifc.push_valid && ifc.push_ready;
      cyc();
      if (acc) ifc.push_valid = 1'b0;
    end
    idle();
    check("drain_n", 32'(got.size()), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) check("drain_order", got[i], 32'(i * 4));
    check("drain_empty", 32'(ifc.count), 0);

    // Simultaneous push/pop at count 2
    ifc.push_valid = 1'b1;
    ifc.push_pc = 32'h8; ifc.push_inst = 32'h0080_0113;
    cyc();
    ifc.push_pc = 32'hC; ifc.push_inst = 32'h00C0_0113;
    cyc();
    ifc.push_pc = 32'h20; ifc.push_inst = 32'h0200_0113;
    ifc.pop_ready = 1'b1;
    check("pp_head_before", ifc.pop_pc, 32'h8);
    cyc();
    idle();
    check("pp_count", 32'(ifc.count), 2);
    check("pp_head",  ifc.pop_pc,     32'hC);

    // Pointer wrap under continuous push+pop; order checked by the model
    for (int k = 0; k < 3 * DEPTH; k++) begin
      ifc.push_valid = 1'b1;
      ifc.pop_ready  = 1'b1;
      ifc.push_pc    = 32'h100 + 32'(k * 4);
      ifc.push_inst  = 32'h0000_0093 | (32'(k) << 20);
      cyc();
    end
    check("wrap_count", 32'(ifc.count), 2);
    check("wrap_head",  ifc.pop_pc,     32'h100 + 32'((3 * DEPTH - 2) * 4));
    ifc.push_valid = 1'b0;
    for (int k = 0; k < 2 * DEPTH && ifc.count != 0; k++) cyc();
    idle();
    check("wrap_drained", 32'(ifc.count), 0);

    // Flush beats a coincident push and pop
    for (int i = 0; i < 3; i++) begin
      ifc.push_valid = 1'b1;
      ifc.push_pc    = 32'h40 + 32'(i * 4);
      ifc.push_inst  = 32'h0010_0193;
      cyc();
    end
    check("flush_pre_count", 32'(ifc.count), 3);
    ifc.flush      = 1'b1;
    ifc.pop_ready  = 1'b1;
    ifc.push_pc    = 32'h99C;
    ifc.push_inst  = 32'h0070_0213;
    cyc();
    idle();
    check("flush_count", 32'(ifc.count),     0);
    check("flush_valid", 32'(ifc.pop_valid), 0);
    check("flush_pc",    ifc.pop_pc,         0);
    cyc();
    check("flush_absent", 32'(ifc.count), 0);

    // Bypass / latency on an empty queue
    ifc.push_valid = 1'b1;
    ifc.pop_ready  = 1'b1;
    ifc.push_pc    = 32'h200;
    ifc.push_inst  = 32'h0020_8133;
    #1;
`ifdef IFQ_BYPASS_EN
    check("byp_valid", 32'(ifc.pop_valid), 1);
    check("byp_inst",  ifc.pop_inst,       32'h0020_8133);
    check("byp_count", 32'(ifc.count),     0);
    cyc();
    idle();
    check("byp_nowrite", 32'(ifc.count), 0);
`else
    check("lat_valid0", 32'(ifc.pop_valid), 0);
    cyc();
    ifc.push_valid = 1'b0;
    check("lat_valid1", 32'(ifc.pop_valid), 1);
    check("lat_inst",   ifc.pop_inst,       32'h0020_8133);
    cyc();
    idle();
    check("lat_drained", 32'(ifc.count), 0);
`endif

    // Asynchronous reset mid-cycle with two entries queued
    ifc.push_valid = 1'b1;
    ifc.push_pc = 32'h300; ifc.push_inst = 32'h0030_0093;
    cyc();
    ifc.push_pc = 32'h304; ifc.push_inst = 32'h0040_0093;
    cyc();
    idle();
    check("mid_pre_count", 32'(ifc.count), 2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_count",      32'(ifc.count),      0);
    check("mid_rst_valid",      32'(ifc.pop_valid),  0);
    check("mid_rst_inst",       ifc.pop_inst,        32'h0000_0013);
    check("mid_rst_pc",         ifc.pop_pc,          0);
    check("mid_rst_push_ready", 32'(ifc.push_ready), 1);
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_count", 32'(ifc.count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Small instruction FIFO between the fetch stage and decode.
- Buffers fetched {pc, instruction} pairs so a decode/rename stall does not back-pressure the AXI fetch path cycle-by-cycle.
- Head entry drives decode; decode hands inst[31:7] to the immediate generator.
- Flushed on branch/jump redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.
- NOP_INST, 32'h00000013, value driven on pop_inst when no valid head (addi x0,x0,0).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  redirect; discard all entries
- push_valid  input  1  fetch presents an instruction
- push_ready  output  1  queue can accept (count != DEPTH)
- push_inst  input  32  fetched instruction word
- push_pc  input  32  PC of push_inst
- pop_valid  output  1  head entry valid
- pop_ready  input  1  decode consumes head
- pop_inst  output  32  head instruction (NOP_INST when !pop_valid)
- pop_imm_field  output  25  pop_inst[31:7], immediate-generator input
- pop_pc  output  32  head PC (0 when !pop_valid)
- count  output  PTR_W+1  current occupancy

Behaviour:
- Interface is fixed: one clock clk; reset rst is asynchronous and active-high.
- Reset state:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - push_ready = 1, pop_valid = 0, pop_inst = NOP_INST, pop_pc = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards everything immediately (async), with no partial writes.
- Handshake:
  - Push fires on push_valid && push_ready.
  - Pop fires on pop_valid && pop_ready.
  - push_ready depends only on registered count; there is no combinational path from pop_ready or flush.
- Push fire: mem[wr_ptr] <= {push_pc, push_inst}; wr_ptr <= wr_ptr+1, wrapping mod DEPTH.
- Pop fire: rd_ptr <= rd_ptr+1, wrapping mod DEPTH.
- Occupancy update:
  - Push only: count+1.
  - Pop only: count-1.
  - Both: count unchanged. This is legal at any occupancy 1..DEPTH-1.
  - At full, push_ready = 0, so no push fires even if a pop fires in the same cycle.
- Head output:
  - pop_valid = (count != 0).
  - pop_inst and pop_pc are read combinationally from mem[rd_ptr] and forced to NOP_INST and 0 when !pop_valid.
- Latency: push-to-pop_valid is 1 cycle (entry visible the cycle after the push fires). Throughput is 1 instruction per cycle in steady state.
- Flush:
  - Synchronous, highest priority. Next cycle wr_ptr = rd_ptr = 0, count = 0.
  - A push or pop coinciding with flush is dropped and has no effect.
  - Fetch must re-present the redirected instruction after the flush.
- Error cases:
  - Pop when empty cannot fire because pop_valid = 0.
  - push_valid while full is held by fetch; no data is lost.
- Assertions (simulation only):
  - count <= DEPTH.
  - count == (wr_ptr - rd_ptr) mod DEPTH, except when full.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined:
  - When count == 0 and push_valid and pop_ready, the push data passes combinationally to pop_inst/pop_pc with pop_valid = 1.
  - Nothing is written; pointers and count are unchanged. Latency is 0 for that case.
  - Bypass is suppressed while flush = 1.
- Undefined: no combinational path from push_* to pop_*. Latency is always 1 cycle.

Test Plan:
1. Reset sequencing: assert rst mid-cycle with 2 entries queued -> immediately count = 0, pop_valid = 0, pop_inst = 32'h00000013, pop_pc = 0, push_ready = 1.
2. Single entry: push inst 32'h00500093, pc 32'h00000100, with pop_ready = 0 -> next cycle pop_valid = 1, pop_inst = 32'h00500093, pop_imm_field = 25'h00A001, pop_pc = 32'h100, count = 1.
3. Fill and stall:
   - Push 5 consecutive instructions (pc 0x0, 0x4, 0x8, 0xC, 0x10) with pop_ready = 0.
   - Expect push_ready = 0 after the 4th push and count = 4; the 5th is held.
   - Then pop_ready = 1 -> PCs pop in order 0x0, 0x4, 0x8, 0xC, then 0x10 after it is accepted.
4. Simultaneous push/pop:
   - Count = 2; push pc 0x20 and pop head pc 0x8 in the same cycle -> count stays 2, next head pc 0xC.
   - Run 3*DEPTH cycles of push+pop to exercise pointer wrap; order must be preserved.
5. Flush priority: count = 3, assert flush with push_valid = 1 and pop_ready = 1 -> next cycle count = 0, pop_valid = 0; the pushed instruction is absent.
6. Bypass check:
   - IFQ_BYPASS_EN defined: empty queue, push 32'h00208133 with pop_ready = 1 -> same cycle pop_valid = 1, pop_inst = 32'h00208133, count stays 0.
   - IFQ_BYPASS_EN undefined: pop_valid asserts 1 cycle later.
